// File: rtl/md_seq_pkg.sv
// Shared encodings for the multdiv sequencer: FSM states, decode constants,
// exception status codes and default parameter values.
package md_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_WRITE = 2'd2
  } md_state_e;

  // Decode values used upstream to raise ex_mult / ex_div.
  localparam logic [4:0] OP_RTYPE   = 5'b00000;
  localparam logic [4:0] ALUOP_MULT = 5'b00110;
  localparam logic [4:0] ALUOP_DIV  = 5'b00111;

  localparam logic [31:0] EXC_MULT    = 32'd4;
  localparam logic [31:0] EXC_DIV     = 32'd5;
  localparam logic [31:0] EXC_TIMEOUT = 32'd6;

  localparam int RSTATUS_DEFAULT = 30;
  localparam int TIMEOUT_DEFAULT = 63;

  function automatic logic [31:0] exc_code(input logic is_div);
    return is_div ? EXC_DIV : EXC_MULT;
  endfunction

endpackage

// File: rtl/md_wb_arbiter.sv
// Regfile write-port mux: M/W writeback always wins; the buffered multdiv
// write goes out only when M/W is idle, with r0 targets suppressed.
module md_wb_arbiter
  import md_seq_pkg::*;
(
  input  logic        rst_n,
  input  logic        buf_pending,
  input  logic [4:0]  buf_rd,
  input  logic [31:0] buf_data,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        buf_taken,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  assign buf_taken = rst_n & buf_pending & ~wb_valid;

  always_comb begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'd0;
    if (buf_taken) begin
      ctrl_writeEnable = (buf_rd != 5'd0);
      ctrl_writeReg    = buf_rd;
      data_writeReg    = buf_data;
    end else if (rst_n) begin
      // Pass-through writes to r0 are forwarded; the regfile drops them.
      ctrl_writeEnable = wb_valid;
      ctrl_writeReg    = wb_rd;
      data_writeReg    = wb_data;
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Issue/stall/writeback controller around the iterative multiplier/divider:
// IDLE issues, BUSY waits for md_ready or timeout, WRITE retires the result.
module md_sequencer
  import md_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int RSTATUS = RSTATUS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_mult,
  input  logic        ex_div,
  input  logic [4:0]  ex_rd,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic        stall,
  output logic        xm_bubble,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        md_timeout
);

  localparam int              CW          = $clog2(TIMEOUT + 1);
  localparam logic [4:0]      RSTATUS_REG = 5'(RSTATUS);
  localparam logic [CW-1:0]   CNT_LAST    = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CNT_ONE     = CW'(1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic        div_q, div_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        timeout_q, timeout_d;

  logic in_idle;
  logic issue;
  logic buf_taken;

  // Start pulses are combinational so the unit starts in the issue cycle.
  assign in_idle      = reset & (state_q == ST_IDLE);
  assign md_ctrl_mult = in_idle & ex_mult;
  assign md_ctrl_div  = in_idle & ex_div & ~ex_mult;
  assign issue        = md_ctrl_mult | md_ctrl_div;

  assign stall      = (state_q != ST_IDLE);
  assign xm_bubble  = (state_q != ST_IDLE);
  assign md_timeout = timeout_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    div_d      = div_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (issue) begin
          rd_d    = ex_rd;
          div_d   = ~ex_mult;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_ONE;
        if (md_ready) begin
          state_d = ST_WRITE;
          if (md_exception) begin
            buf_rd_d   = RSTATUS_REG;
            buf_data_d = exc_code(div_q);
          end else begin
            buf_rd_d   = rd_q;
            buf_data_d = md_result;
          end
        end else if (cnt_q == CNT_LAST) begin
          // This is the TIMEOUT-th BUSY cycle without a result.
          buf_rd_d   = RSTATUS_REG;
          buf_data_d = EXC_TIMEOUT;
          timeout_d  = 1'b1;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (buf_taken) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_q       <= 5'd0;
      div_q      <= 1'b0;
      buf_rd_q   <= 5'd0;
      buf_data_q <= 32'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      div_q      <= div_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      timeout_q  <= timeout_d;
    end
  end

  md_wb_arbiter u_arb (
    .rst_n            (reset),
    .buf_pending      (state_q == ST_WRITE),
    .buf_rd           (buf_rd_q),
    .buf_data         (buf_data_q),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .buf_taken        (buf_taken),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed cycle checks plus a
// scoreboard of expected regfile writes compared as the port fires.
module tb_md_sequencer;

  logic        clock;
  logic        reset;
  logic        ex_mult, ex_div;
  logic [4:0]  ex_rd;
  logic        md_ready, md_exception;
  logic [31:0] md_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        md_ctrl_mult, md_ctrl_div, stall, xm_bubble;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        md_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];

  md_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .ex_mult          (ex_mult),
    .ex_div           (ex_div),
    .ex_rd            (ex_rd),
    .md_ready         (md_ready),
    .md_exception     (md_exception),
    .md_result        (md_result),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .md_ctrl_mult     (md_ctrl_mult),
    .md_ctrl_div      (md_ctrl_div),
    .stall            (stall),
    .xm_bubble        (xm_bubble),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .md_timeout       (md_timeout)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every regfile write the port shows must be the next expected one.
  always @(negedge clock) begin
    if (ctrl_writeEnable === 1'b1) begin
      if (exp_q.size() == 0)
        check_eq("sb_unexpected_write", {ctrl_writeReg, data_writeReg}, 64'h0);
      else
        check_eq("sb_write", {ctrl_writeReg, data_writeReg}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_op(input logic do_mult, input logic do_div, input logic [4:0] rd,
                        input int lat, input logic exc, input logic [31:0] res,
                        input int n_wb);
    logic [4:0]  tgt;
    logic [31:0] tdata;
    logic        is_div;
    is_div = ~do_mult;
    tgt    = exc ? 5'd30 : rd;
    tdata  = exc ? (is_div ? 32'd5 : 32'd4) : res;
    // cycle T: issue
    ex_mult = do_mult;
    ex_div  = do_div;
    ex_rd   = rd;
    @(negedge clock);
    check_eq("ctrl_mult_T", md_ctrl_mult, do_mult);
    check_eq("ctrl_div_T", md_ctrl_div, do_div & ~do_mult);
    check_eq("stall_T", stall, 0);
    tick();
    // cycle T+1: frozen X instruction still requests; must be ignored
    ex_rd = 5'($urandom);
    @(negedge clock);
    check_eq("stall_T1", stall, 1);
    check_eq("bubble_T1", xm_bubble, 1);
    check_eq("ctrl_mult_busy", md_ctrl_mult, 0);
    check_eq("ctrl_div_busy", md_ctrl_div, 0);
    tick();
    ex_mult = 1'b0;
    ex_div  = 1'b0;
    for (int i = 2; i < lat; i++) begin
      @(negedge clock);
      check_eq("stall_busy", stall, 1);
      tick();
    end
    // cycle R
    md_ready     = 1'b1;
    md_exception = exc;
    md_result    = res;
    @(negedge clock);
    check_eq("we_R", ctrl_writeEnable, 0);
    check_eq("stall_R", stall, 1);
    tick();
    md_ready     = 1'b0;
    md_exception = 1'b0;
    md_result    = $urandom;
    for (int i = 0; i < n_wb; i++) begin
      wb_valid = 1'b1;
      wb_rd    = 5'($urandom_range(1, 31));
      wb_data  = $urandom;
      exp_q.push_back({wb_rd, wb_data});
      @(negedge clock);
      check_eq("wb_pass", ctrl_writeEnable, 1);
      check_eq("stall_conflict", stall, 1);
      tick();
    end
    wb_valid = 1'b0;
    if (tgt != 5'd0) exp_q.push_back({tgt, tdata});
    @(negedge clock);
    check_eq("we_buf", ctrl_writeEnable, tgt != 5'd0);
    check_eq("stall_wr", stall, 1);
    check_eq("timeout_none", md_timeout, 0);
    tick();
    @(negedge clock);
    check_eq("stall_release", stall, 0);
    check_eq("bubble_release", xm_bubble, 0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    ex_mult = 1'b1; ex_div = 1'b1; ex_rd = 5'd3;
    md_ready = 1'b0; md_exception = 1'b0; md_result = 32'd0;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h1234_5678;
    @(negedge clock);
    check_eq("rst_we", ctrl_writeEnable, 0);
    check_eq("rst_reg", ctrl_writeReg, 0);
    check_eq("rst_data", data_writeReg, 0);
    check_eq("rst_ctrl", {md_ctrl_mult, md_ctrl_div}, 0);
    check_eq("rst_stall", {stall, xm_bubble, md_timeout}, 0);
    tick();
    reset = 1'b1; ex_mult = 1'b0; ex_div = 1'b0; wb_valid = 1'b0;
    tick();

    // pass-through to r0 is forwarded unchanged
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hdead_0000;
    exp_q.push_back({5'd0, 32'hdead_0000});
    @(negedge clock);
    check_eq("wb_r0_pass", ctrl_writeEnable, 1);
    tick();
    wb_valid = 1'b0;

    run_op(1'b1, 1'b0, 5'd5, 17, 1'b0, 32'd42, 0);           // mult, no conflict
    run_op(1'b0, 1'b1, 5'd7, 9, 1'b1, 32'hffff_ffff, 0);     // div by zero
    run_op(1'b1, 1'b0, 5'd12, 5, 1'b0, 32'h0bad_cafe, 2);    // port conflict
    run_op(1'b1, 1'b0, 5'd13, 4, 1'b1, 32'd0, 1);            // mult exception
    run_op(1'b1, 1'b1, 5'd0, 6, 1'b0, 32'd99, 0);            // both, rd=0

    // timeout: T issue, 63 BUSY cycles, abandon pulse in first WRITE cycle
    ex_mult = 1'b1; ex_rd = 5'd21;
    @(negedge clock);
    check_eq("to_ctrl", md_ctrl_mult, 1);
    tick();
    ex_mult = 1'b0;
    for (int i = 1; i <= 63; i++) begin
      @(negedge clock);
      check_eq("to_stall", stall, 1);
      check_eq("to_pulse_early", md_timeout, 0);
      tick();
    end
    exp_q.push_back({5'd30, 32'd6});
    @(negedge clock);
    check_eq("to_pulse", md_timeout, 1);
    check_eq("to_we", ctrl_writeEnable, 1);
    tick();
    md_ready = 1'b1; md_exception = 1'b1; md_result = 32'd77;
    @(negedge clock);
    check_eq("to_pulse_end", md_timeout, 0);
    check_eq("to_idle", stall, 0);
    tick();
    md_ready = 1'b0; md_exception = 1'b0;
    @(negedge clock);
    check_eq("late_ready_ignored", {stall, ctrl_writeEnable}, 0);
    tick();

    // reset mid-operation
    ex_div = 1'b1; ex_rd = 5'd11;
    tick();
    ex_div = 1'b0;
    tick();
    tick();
    reset = 1'b0; wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h5555_aaaa; ex_div = 1'b1;
    md_ready = 1'b1;
    @(negedge clock);
    check_eq("mid_rst_stall", {stall, xm_bubble, md_timeout}, 0);
    check_eq("mid_rst_ctrl", {md_ctrl_mult, md_ctrl_div}, 0);
    check_eq("mid_rst_port", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, 0);
    tick();
    reset = 1'b1; wb_valid = 1'b0; ex_div = 1'b0; md_ready = 1'b0;
    @(negedge clock);
    check_eq("post_rst_idle", stall, 0);
    tick();
    run_op(1'b0, 1'b1, 5'd9, 6, 1'b0, 32'h0000_0123, 1);

    // randomized operations
    for (int k = 0; k < 6; k++) begin
      logic m;
      m = 1'($urandom_range(0, 1));
      run_op(m, ~m, 5'($urandom_range(1, 31)), $urandom_range(2, 20),
             ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 2));
    end

    check_eq("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Sequencing controller for the pipelined processor's iterative multiplier/divider. It detects a `mult`/`div` in the execute stage and issues a one-cycle start pulse to the multdiv unit. While the unit runs, it freezes the front of the pipeline and bubbles the memory stage. When the result is ready, it writes it (or an exception status to `$r30`) back through the single regfile write port, arbitrating against the normal M/W writeback.

## Interface
Parameters:
- `TIMEOUT`, 63: BUSY cycles without `md_ready` before the operation is abandoned.
- `RSTATUS`, 30: register that receives exception codes.

Ports:
- `clock`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-low.
- `ex_mult`, in, 1: a `mult` is in the X stage (opcode 00000, ALUop 00110).
- `ex_div`, in, 1: a `div` is in the X stage (ALUop 00111).
- `ex_rd`, in, 5: destination register of the X-stage instruction.
- `md_ready`, in, 1: multdiv result valid (one-cycle pulse).
- `md_exception`, in, 1: multdiv exception, qualified by `md_ready`.
- `md_result`, in, 32: multdiv result.
- `wb_valid`, in, 1: M/W stage requests a regfile write.
- `wb_rd`, in, 5: M/W stage destination register.
- `wb_data`, in, 32: M/W stage write data.
- `md_ctrl_mult`, out, 1: start pulse to multdiv.
- `md_ctrl_div`, out, 1: start pulse to multdiv.
- `stall`, out, 1: hold the PC, F/D and D/X latches.
- `xm_bubble`, out, 1: force a nop into X/M.
- `ctrl_writeEnable`, out, 1: arbitrated regfile write enable.
- `ctrl_writeReg`, out, 5: arbitrated regfile write register.
- `data_writeReg`, out, 32: arbitrated regfile write data.
- `md_timeout`, out, 1: one-cycle pulse when an operation is abandoned.

## Operation
States are IDLE, BUSY and WRITE.
- **IDLE**
  - `md_ctrl_mult = ex_mult`; `md_ctrl_div = ex_div & ~ex_mult` (mult wins if both are set). These are combinational and asserted in the issue cycle only.
  - On issue: latch `ex_rd`, record mult or div, clear the counter, go to BUSY.
- **BUSY**
  - `stall = 1` and `xm_bubble = 1`. The counter increments each cycle.
  - On `md_ready`, capture into the buffer, then go to WRITE:
    - if `md_exception`: target `RSTATUS`, data 32'd4 (mult) or 32'd5 (div);
    - otherwise: target the latched rd, data `md_result`.
  - If the counter reaches `TIMEOUT` with no `md_ready`: buffer `RSTATUS` with 32'd6, pulse `md_timeout`, go to WRITE.
- **WRITE**
  - `stall = 1` and `xm_bubble = 1`.
  - If `wb_valid` is high, M/W has priority: its write passes through and the state holds.
  - Otherwise drive the buffered write, then go to IDLE.
  - A buffered target of r0 gives `ctrl_writeEnable = 0` but still completes.
- **Write port**: passes through `wb_*` in every state except the buffered-write cycle of WRITE.
  - A pass-through write to r0 is forwarded unchanged; the regfile ignores it.
- **Issue requests outside IDLE**: `ex_mult`/`ex_div` are ignored in BUSY and WRITE. The X-stage instruction is frozen and re-evaluated on release.
- **Reset** (asserted at any time, including mid-operation):
  - forces IDLE and clears the buffer and counter;
  - all outputs are 0, and the write port shows `wb_*` gated by `reset`;
  - no start pulse is issued while `reset` is low.
- **Late `md_ready` after a timeout** (i.e. in IDLE): ignored.

## Timing
- Issue in cycle T → `stall` and `xm_bubble` high from T+1.
- `md_ready` in cycle R → buffered write in R+1 if `wb_valid` is low there. Otherwise the write occurs in the first later cycle with `wb_valid` low. This is at most R+3, because the front is frozen and X/M bubbled, so M/W drains within 2 cycles.
- `stall` falls in the cycle after the buffered write, in IDLE.
- Back-to-back mult/div: a new issue is accepted in the first IDLE cycle.
- Minimum issue-to-issue spacing is 3 cycles plus the multdiv latency.
- `stall` and `xm_bubble` are registered state decodes with no combinational path from `md_ready`.
- `md_ctrl_*` are combinational from `ex_*`, gated to IDLE.

## Structure
- **Package `md_seq_pkg`** holds:
  - the state encoding (IDLE, BUSY, WRITE);
  - opcode 5'b00000 and ALUops 5'b00110 / 5'b00111;
  - exception codes 4, 5, 6;
  - default `RSTATUS`.
- **Sub-module `md_wb_arbiter`**: combinational 2:1 write-port mux, with M/W priority and r0 suppression for the buffered write.
- **Top level**: the FSM, counter and result buffer.

## Test plan
- **Mult, no conflict**: `ex_mult`, rd=5, `md_ready` 17 cycles later with result 42, `wb_valid` = 0. Expect:
  - `md_ctrl_mult` for one cycle;
  - `stall` high from T+1;
  - write r5 = 42 at R+1;
  - `stall` low at R+2.
- **Div by zero**: `ex_div`, rd=7, `md_ready` with `md_exception`. Expect r30 = 5, and r7 is not written.
- **Port conflict**: `md_ready` with `wb_valid` high in R+1 and R+2. Expect:
  - M/W writes pass through in R+1 and R+2;
  - the multdiv write occurs at R+3;
  - `stall` is held until then.
- **Timeout**: `ex_mult` with no `md_ready` for 63 BUSY cycles. Expect a `md_timeout` pulse, r30 = 6, and return to IDLE; a later `md_ready` is ignored.
- **Reset mid-operation**: `reset` low in BUSY. Expect all outputs 0 immediately. After release, a new `ex_div` issues normally.
- **Simultaneous `ex_mult` and `ex_div`; rd=0**: expect only `md_ctrl_mult`. The result completes with `ctrl_writeEnable` = 0, and `stall` is released normally.
